// File: rtl/bw_product_accumulator.sv
// Signed product accumulator: sums accLen handshaked products into one dot-product result
// and holds that result on a valid/ready output until the consumer takes it.
module bw_product_accumulator #(
    parameter  int numBit = 4,
    parameter  int accLen = 8,
    localparam int accBit = 2*numBit + $clog2(accLen)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [2*numBit-1:0]       prod_in,
    input  logic                      prod_valid_in,
    output logic                      prod_ready_out,
    input  logic                      flush_in,
    output logic [accBit-1:0]         acc_out,
    output logic                      acc_valid_out,
    input  logic                      acc_ready_in,
    output logic [$clog2(accLen):0]   count_out
);

    localparam int   cntBit   = $clog2(accLen) + 1;
    localparam int   extBit   = accBit - 2*numBit;
    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    logic              state_q, state_d;
    logic [accBit-1:0] acc_q, acc_d;
    logic [accBit-1:0] res_q, res_d;
    logic              res_valid_q, res_valid_d;
    logic [cntBit-1:0] cnt_q, cnt_d;

    logic [accBit-1:0] prod_ext;
    logic [accBit-1:0] acc_sum;
    logic              in_xfer;
    logic              last_prod;

    // Flush blocks acceptance so a flushed cycle can never also count a product.
    assign prod_ready_out = (state_q == ST_ACCUM) && !flush_in;
    assign in_xfer        = prod_valid_in && prod_ready_out;
    assign prod_ext       = {{extBit{prod_in[2*numBit-1]}}, prod_in};
    assign acc_sum        = acc_q + prod_ext;
    assign last_prod      = (cnt_q == cntBit'(accLen - 1));

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no branch can infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_ACCUM: begin
                if (flush_in) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (in_xfer) begin
                    if (last_prod) begin
                        res_d       = acc_sum;
                        res_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + cntBit'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (res_valid_q && acc_ready_in) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
        if (rst_in) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign acc_out       = res_q;
    assign acc_valid_out = res_valid_q;
    assign count_out     = cnt_q;

endmodule

// File: tb/tb_bw_product_accumulator.sv
// Bench for bw_product_accumulator (numBit=4, accLen=8): directed scenarios plus randomized
// throttling against a transaction-level reference model.
module tb_bw_product_accumulator;

    localparam int ACC_LEN = 8;
    localparam int ACC_BIT = 11;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic [7:0]         prod_in = '0;
    logic               prod_valid_in = 1'b0;
    logic               prod_ready_out;
    logic               flush_in = 1'b0;
    logic [ACC_BIT-1:0] acc_out;
    logic               acc_valid_out;
    logic               acc_ready_in = 1'b0;
    logic [3:0]         count_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (plain integers)
    int mdl_sum    = 0;
    int mdl_cnt    = 0;
    bit mdl_hold   = 1'b0;
    bit mdl_valid  = 1'b0;
    int mdl_result = 0;
    int mdl_done   = 0;

    bw_product_accumulator #(.numBit(4), .accLen(ACC_LEN)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .prod_in        (prod_in),
        .prod_valid_in  (prod_valid_in),
        .prod_ready_out (prod_ready_out),
        .flush_in       (flush_in),
        .acc_out        (acc_out),
        .acc_valid_out  (acc_valid_out),
        .acc_ready_in   (acc_ready_in),
        .count_out      (count_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic exp_ready();
        return !mdl_hold && !flush_in;
    endfunction

    function automatic logic [ACC_BIT-1:0] exp_acc();
        return ACC_BIT'(mdl_result);
    endfunction

    task automatic set_inputs(input logic v, input logic [7:0] p, input logic f,
                              input logic r, input logic rst);
        @(negedge clk_in);
        prod_valid_in = v;
        prod_in       = p;
        flush_in      = f;
        acc_ready_in  = r;
        rst_in        = rst;
        #1;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        @(posedge clk_in);
        if (rst_in) begin
            mdl_sum = 0; mdl_cnt = 0; mdl_hold = 1'b0; mdl_valid = 1'b0; mdl_result = 0;
        end else if (!mdl_hold) begin
            if (flush_in) begin
                mdl_sum = 0; mdl_cnt = 0;
            end else if (prod_valid_in) begin
                mdl_sum = mdl_sum + int'($signed(prod_in));
                mdl_cnt = mdl_cnt + 1;
                if (mdl_cnt == ACC_LEN) begin
                    mdl_result = mdl_sum;
                    mdl_valid  = 1'b1;
                    mdl_hold   = 1'b1;
                    mdl_sum    = 0;
                    mdl_cnt    = 0;
                    mdl_done   = mdl_done + 1;
                end
            end
        end else if (acc_ready_in) begin
            mdl_valid = 1'b0;
            mdl_hold  = 1'b0;
        end
        #1;
    endtask

    task automatic run_const(input logic [7:0] p, input int n, input logic r);
        for (int i = 0; i < n; i++) begin
            set_inputs(1'b1, p, 1'b0, r, 1'b0);
            tick();
        end
        set_inputs(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        set_inputs(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        set_inputs(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        set_inputs(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (acc_out !== '0 || acc_valid_out !== 1'b0 || count_out !== 4'd0 || prod_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: acc=%h valid=%b cnt=%0d ready=%b, want 000 0 0 1",
                     acc_out, acc_valid_out, count_out, prod_ready_out);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < ACC_LEN; i++) begin
            set_inputs(1'b1, 8'sd64, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (count_out !== 4'(i) || prod_ready_out !== 1'b1 || acc_valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b.step%0d: cnt=%0d ready=%b valid=%b, want %0d 1 0",
                         i, count_out, prod_ready_out, acc_valid_out, i);
            end
            tick();
        end
        n_checks++;
        if (acc_valid_out !== 1'b1 || acc_out !== 11'd512) begin
            n_fail++;
            $display("FAIL b2b.result: valid=%b acc=%0d, want 1 512", acc_valid_out, acc_out);
        end
        set_inputs(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (acc_valid_out !== 1'b0 || acc_out !== 11'd512 || prod_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b.one_cycle: valid=%b acc=%0d ready=%b, want 0 512 1",
                     acc_valid_out, acc_out, prod_ready_out);
        end
    endtask

    task automatic test_signed();
        run_const(8'hC8, ACC_LEN, 1'b1);
        n_checks++;
        if (acc_valid_out !== 1'b1 || acc_out !== 11'h640) begin
            n_fail++;
            $display("FAIL signed.neg: valid=%b acc=%h, want 1 640", acc_valid_out, acc_out);
        end
        drain();
        run_const(8'sd49, ACC_LEN, 1'b1);
        n_checks++;
        if (acc_valid_out !== 1'b1 || acc_out !== 11'd392) begin
            n_fail++;
            $display("FAIL signed.pos: valid=%b acc=%0d, want 1 392", acc_valid_out, acc_out);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] mixed [8];
        mixed = '{8'sd64, -8'sd56, 8'sd1, -8'sd1, 8'sd7, -8'sd8, 8'sd0, 8'sd3};
        for (int i = 0; i < ACC_LEN; i++) begin
            set_inputs(1'b1, mixed[i], 1'b0, 1'b0, 1'b0);
            tick();
        end
        n_checks++;
        if (acc_valid_out !== 1'b1 || acc_out !== 11'd10) begin
            n_fail++;
            $display("FAIL hold.result: valid=%b acc=%0d, want 1 10", acc_valid_out, acc_out);
        end
        // Consumer stalls; upstream keeps offering and a flush attempt must not discard the result.
        for (int i = 0; i < 5; i++) begin
            set_inputs(1'b1, 8'sd5, (i == 2), 1'b0, 1'b0);
            n_checks++;
            if (prod_ready_out !== 1'b0 || acc_valid_out !== 1'b1 || acc_out !== 11'd10 || count_out !== 4'd0) begin
                n_fail++;
                $display("FAIL hold.stall%0d: ready=%b valid=%b acc=%0d cnt=%0d, want 0 1 10 0",
                         i, prod_ready_out, acc_valid_out, acc_out, count_out);
            end
            tick();
        end
        set_inputs(1'b1, 8'sd5, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (acc_valid_out !== 1'b0 || count_out !== 4'd0 || prod_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL hold.release: valid=%b cnt=%0d ready=%b, want 0 0 1",
                     acc_valid_out, count_out, prod_ready_out);
        end
        run_const(8'sd5, ACC_LEN, 1'b0);
        n_checks++;
        if (acc_valid_out !== 1'b1 || acc_out !== 11'd40) begin
            n_fail++;
            $display("FAIL hold.no_loss: valid=%b acc=%0d, want 1 40", acc_valid_out, acc_out);
        end
        drain();
    endtask

    task automatic test_flush();
        run_const(8'sd10, 3, 1'b1);
        set_inputs(1'b1, 8'sd10, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (prod_ready_out !== 1'b0 || count_out !== 4'd3) begin
            n_fail++;
            $display("FAIL flush.pre: ready=%b cnt=%0d, want 0 3", prod_ready_out, count_out);
        end
        tick();
        set_inputs(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (count_out !== 4'd0 || acc_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush.cnt: cnt=%0d valid=%b, want 0 0", count_out, acc_valid_out);
        end
        run_const(8'sd1, ACC_LEN, 1'b1);
        n_checks++;
        if (acc_valid_out !== 1'b1 || acc_out !== 11'd8) begin
            n_fail++;
            $display("FAIL flush.result: valid=%b acc=%0d, want 1 8", acc_valid_out, acc_out);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        run_const(8'sd3, 5, 1'b1);
        set_inputs(1'b1, 8'sd3, 1'b0, 1'b1, 1'b1);
        tick();
        set_inputs(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (count_out !== 4'd0 || acc_valid_out !== 1'b0 || acc_out !== '0) begin
            n_fail++;
            $display("FAIL rstmid.accum: cnt=%0d valid=%b acc=%0d, want 0 0 0",
                     count_out, acc_valid_out, acc_out);
        end
        run_const(8'sd9, ACC_LEN, 1'b0);
        set_inputs(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        set_inputs(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (count_out !== 4'd0 || acc_valid_out !== 1'b0 || acc_out !== '0 || prod_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid.hold: cnt=%0d valid=%b acc=%0d ready=%b, want 0 0 0 1",
                     count_out, acc_valid_out, acc_out, prod_ready_out);
        end
        run_const(8'sd2, ACC_LEN, 1'b0);
        n_checks++;
        if (acc_valid_out !== 1'b1 || acc_out !== 11'd16) begin
            n_fail++;
            $display("FAIL rstmid.result: valid=%b acc=%0d, want 1 16", acc_valid_out, acc_out);
        end
        drain();
    endtask

    task automatic test_random();
        int  cycles;
        int  target;
        logic [3:0] a, b;
        logic [7:0] p;
        cycles = 0;
        target = mdl_done + 1000;
        while (mdl_done < target && cycles < 60000) begin
            a = 4'($urandom);
            b = 4'($urandom);
            p = 8'($signed(a) * $signed(b));
            set_inputs(($urandom_range(0, 9) < 7), p, ($urandom_range(0, 49) == 0),
                       ($urandom_range(0, 9) < 6), 1'b0);
            n_checks++;
            if (prod_ready_out !== exp_ready()) begin
                n_fail++;
                $display("FAIL random.ready c%0d: got %b want %b", cycles, prod_ready_out, exp_ready());
            end
            tick();
            n_checks++;
            if (acc_valid_out !== mdl_valid || acc_out !== exp_acc() || count_out !== 4'(mdl_cnt)) begin
                n_fail++;
                $display("FAIL random.out c%0d: valid=%b acc=%h cnt=%0d, want %b %h %0d",
                         cycles, acc_valid_out, acc_out, count_out, mdl_valid, exp_acc(), mdl_cnt);
            end
            cycles++;
        end
        n_checks++;
        if (mdl_done < target) begin
            n_fail++;
            $display("FAIL random.timeout: %0d results left after %0d cycles", target - mdl_done, cycles);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_signed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
